// File: rtl/reset_sequencer_if.sv
// Software-reset handshake bundle between the system controller, the three
// reset domains and the reset sequencer (slave = the sequencer).
interface reset_sequencer_if;
   logic       SoftwareResetIn;
   logic [3:0] ResetVectorIn;
   logic       ResetResponseOut;
   logic       FullResetOut;
   logic       DataResetReq;
   logic       IOResetReq;
   logic       InstResetReq;
   logic       DataResetAck;
   logic       IOResetAck;
   logic       InstResetAck;
   logic       Busy;
   logic [2:0] TimedOutDomains;

   // Controller plus domains as seen from the outside.
   modport master (
      output SoftwareResetIn, ResetVectorIn,
      output DataResetAck, IOResetAck, InstResetAck,
      input  ResetResponseOut, FullResetOut,
      input  DataResetReq, IOResetReq, InstResetReq,
      input  Busy, TimedOutDomains
   );

   modport slave (
      input  SoftwareResetIn, ResetVectorIn,
      input  DataResetAck, IOResetAck, InstResetAck,
      output ResetResponseOut, FullResetOut,
      output DataResetReq, IOResetReq, InstResetReq,
      output Busy, TimedOutDomains
   );
endinterface

// File: rtl/reset_sequencer.sv
// Responder side of the software-reset handshake: optional full-reset hold,
// then Data/IO domains, then Inst domain, then a one-cycle completion pulse.
module reset_sequencer #(
   parameter int FULL_HOLD_CYCLES = 4,
   parameter int TIMEOUT_CYCLES   = 256,
   parameter int TIMER_W          = 9
) (
   input  logic             clk,
   input  logic             async_rst,
   input  logic             clk_en,
   reset_sequencer_if.slave bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_FULL_HOLD, S_PHASE1, S_PHASE2, S_RESPOND
   } state_e;

   localparam logic [TIMER_W-1:0] FULL_LAST = TIMER_W'(FULL_HOLD_CYCLES - 1);
   localparam logic [TIMER_W-1:0] TMO_LAST  = TIMER_W'(TIMEOUT_CYCLES - 1);
   localparam bit                 TMO_EN    = (TIMEOUT_CYCLES != 0);

   state_e               state_q;
   logic [TIMER_W-1:0]   timer_q;
   logic [2:0]           mask_q;   // {Inst, IO, Data} still to be reset
   logic [2:0]           tmo_q;
   logic                 full_q;
   logic                 dreq_q;
   logic                 ioreq_q;
   logic                 ireq_q;
   logic                 resp_q;

   logic                 tmo_hit;
   logic [1:0]           p1_ack;
   logic [1:0]           p1_left_d;
   logic                 inst_ack;

   // Acks only count while their own request is raised.
   always_comb begin
      tmo_hit   = TMO_EN && (timer_q == TMO_LAST);
      p1_ack    = {bus.IOResetAck & ioreq_q, bus.DataResetAck & dreq_q};
      p1_left_d = mask_q[1:0] & ~p1_ack;
      inst_ack  = bus.InstResetAck & ireq_q;
   end

   always_ff @(posedge clk or posedge async_rst) begin
      if (async_rst) begin
         state_q <= S_IDLE;
         timer_q <= '0;
         mask_q  <= '0;
         tmo_q   <= '0;
         full_q  <= 1'b0;
         dreq_q  <= 1'b0;
         ioreq_q <= 1'b0;
         ireq_q  <= 1'b0;
         resp_q  <= 1'b0;
      end else if (clk_en) begin
         case (state_q)
            S_IDLE: begin
               if (bus.SoftwareResetIn) begin
                  tmo_q   <= '0;
                  timer_q <= '0;
                  if (bus.ResetVectorIn[3]) begin
                     state_q <= S_FULL_HOLD;
                     mask_q  <= 3'b111;
                     full_q  <= 1'b1;
                  end else if (|bus.ResetVectorIn[1:0]) begin
                     state_q <= S_PHASE1;
                     mask_q  <= bus.ResetVectorIn[2:0];
                     dreq_q  <= bus.ResetVectorIn[0];
                     ioreq_q <= bus.ResetVectorIn[1];
                  end else if (bus.ResetVectorIn[2]) begin
                     state_q <= S_PHASE2;
                     mask_q  <= 3'b100;
                     ireq_q  <= 1'b1;
                  end else begin
                     state_q <= S_RESPOND;
                     resp_q  <= 1'b1;
                  end
               end
            end

            S_FULL_HOLD: begin
               if (timer_q == FULL_LAST) begin
                  state_q <= S_PHASE1;
                  timer_q <= '0;
                  full_q  <= 1'b0;
                  dreq_q  <= mask_q[0];
                  ioreq_q <= mask_q[1];
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end

            // Whatever is still pending when the timer expires is flagged and
            // treated as done; an ack in that same cycle already cleared it.
            S_PHASE1: begin
               if (p1_left_d == 2'b00 || tmo_hit) begin
                  if (tmo_hit) tmo_q[1:0] <= tmo_q[1:0] | p1_left_d;
                  mask_q[1:0] <= 2'b00;
                  dreq_q      <= 1'b0;
                  ioreq_q     <= 1'b0;
                  timer_q     <= '0;
                  if (mask_q[2]) begin
                     state_q <= S_PHASE2;
                     ireq_q  <= 1'b1;
                  end else begin
                     state_q <= S_RESPOND;
                     resp_q  <= 1'b1;
                  end
               end else begin
                  mask_q[1:0] <= p1_left_d;
                  dreq_q      <= p1_left_d[0];
                  ioreq_q     <= p1_left_d[1];
                  timer_q     <= timer_q + 1'b1;
               end
            end

            S_PHASE2: begin
               if (inst_ack || tmo_hit) begin
                  if (!inst_ack) tmo_q[2] <= 1'b1;
                  mask_q[2] <= 1'b0;
                  ireq_q    <= 1'b0;
                  state_q   <= S_RESPOND;
                  resp_q    <= 1'b1;
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end

            S_RESPOND: begin
               resp_q  <= 1'b0;
               state_q <= S_IDLE;
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.ResetResponseOut = resp_q;
   assign bus.FullResetOut     = full_q;
   assign bus.DataResetReq     = dreq_q;
   assign bus.IOResetReq       = ioreq_q;
   assign bus.InstResetReq     = ireq_q;
   assign bus.Busy             = (state_q != S_IDLE);
   assign bus.TimedOutDomains  = tmo_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: a per-transaction timeline model predicts every
// output on every enabled cycle; stimulus mixes directed and random sequences.
module tb_reset_sequencer;
  localparam int FH = 4, TMO = 8, TW = 9, L = 64, NEVER = 99;

  logic clk = 1'b0;
  logic async_rst, clk_en;
  int   checks = 0, errors = 0;

  logic [2:0] e_req[L], e_ack[L], e_tmo[L];
  logic       e_full[L], e_rsp[L], e_busy[L];
  logic [2:0] tmo_prev;
  int         last_k;

  reset_sequencer_if bus();

  reset_sequencer #(.FULL_HOLD_CYCLES(FH), .TIMEOUT_CYCLES(TMO), .TIMER_W(TW)) dut (
    .clk(clk), .async_rst(async_rst), .clk_en(clk_en), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int cyc, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Timeline of one transaction; cycle 0 is the enabled request cycle, delays
  // are counted from the start of each domain's phase (>= TMO means no ack).
  task automatic build(input logic [3:0] vec, input int d0, input int d1, input int d2);
    int d[3];
    logic [2:0] sel;
    int t, p, endp, e;
    d = '{d0, d1, d2};
    for (int k = 0; k < L; k++) begin
      e_req[k] = '0; e_ack[k] = '0; e_tmo[k] = '0;
      e_full[k] = 1'b0; e_rsp[k] = 1'b0; e_busy[k] = 1'b0;
    end
    e_tmo[0] = tmo_prev;
    sel = vec[3] ? 3'b111 : vec[2:0];
    t = 1;
    if (vec[3]) begin
      for (int i = 0; i < FH; i++) e_full[t+i] = 1'b1;
      t += FH;
    end
    for (int ph = 0; ph < 2; ph++) begin
      if ((ph == 0 && sel[1:0] != 2'b00) || (ph == 1 && sel[2])) begin
        p = t; endp = p;
        for (int dm = 0; dm < 3; dm++) begin
          if (sel[dm] && ((dm == 2) == (ph == 1))) begin
            if (d[dm] < TMO) begin
              e = p + d[dm];
              e_ack[e][dm] = 1'b1;
            end else begin
              e = p + TMO - 1;
              for (int k = e + 1; k < L; k++) e_tmo[k][dm] = 1'b1;
            end
            for (int k = p; k <= e; k++) e_req[k][dm] = 1'b1;
            if (e > endp) endp = e;
          end
        end
        t = endp + 1;
      end
    end
    e_rsp[t] = 1'b1;
    for (int k = 1; k <= t; k++) e_busy[k] = 1'b1;
    last_k = t + 2;
    tmo_prev = e_tmo[t];
  endtask

  task automatic drive_idle();
    clk_en = 1'b1;
    bus.SoftwareResetIn = 1'b0; bus.ResetVectorIn = '0;
    bus.DataResetAck = 1'b0; bus.IOResetAck = 1'b0; bus.InstResetAck = 1'b0;
  endtask

  task automatic run_seq(input logic [3:0] vec, input int d0, input int d1, input int d2, input bit half_en);
    int k;
    bit en, done;
    build(vec, d0, d1, d2);
    k = 0; done = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      chk("FullResetOut", k, {3'b0, bus.FullResetOut}, {3'b0, e_full[k]});
      chk("Reqs{I,IO,D}", k, {1'b0, bus.InstResetReq, bus.IOResetReq, bus.DataResetReq}, {1'b0, e_req[k]});
      chk("ResetResponseOut", k, {3'b0, bus.ResetResponseOut}, {3'b0, e_rsp[k]});
      chk("Busy", k, {3'b0, bus.Busy}, {3'b0, e_busy[k]});
      chk("TimedOutDomains", k, {1'b0, bus.TimedOutDomains}, {1'b0, e_tmo[k]});
      if (k == last_k) begin
        done = 1'b1;
        break;
      end
      en = (k == 0) ? 1'b1 : (half_en ? 1'($urandom_range(0, 1)) : 1'b1);
      clk_en = en;
      if (en) begin
        // Stray requests while busy and unsolicited acks must be ignored.
        bus.SoftwareResetIn = (k == 0) || (k <= last_k - 2 && $urandom_range(0, 3) == 0);
        bus.ResetVectorIn   = (k == 0) ? vec : 4'($urandom);
        {bus.InstResetAck, bus.IOResetAck, bus.DataResetAck} = e_ack[k] | (~e_req[k] & 3'($urandom));
      end else begin
        bus.SoftwareResetIn = 1'($urandom);
        bus.ResetVectorIn   = 4'($urandom);
        {bus.InstResetAck, bus.IOResetAck, bus.DataResetAck} = 3'($urandom);
      end
      @(posedge clk);
      if (en) k++;
    end
    drive_idle();
    chk("seq_completed", k, {3'b0, done}, 4'h1);
  endtask

  initial begin
    async_rst = 1'b1;
    drive_idle();
    clk_en = 1'b0;
    tmo_prev = '0;
    repeat (2) @(negedge clk);
    chk("rst_Full", 0, {3'b0, bus.FullResetOut}, 4'h0);
    chk("rst_Reqs", 0, {1'b0, bus.InstResetReq, bus.IOResetReq, bus.DataResetReq}, 4'h0);
    chk("rst_Resp", 0, {3'b0, bus.ResetResponseOut}, 4'h0);
    chk("rst_Busy", 0, {3'b0, bus.Busy}, 4'h0);
    chk("rst_Tmo", 0, {1'b0, bus.TimedOutDomains}, 4'h0);
    async_rst = 1'b0;
    clk_en = 1'b1;

    run_seq(4'b0001, 2, NEVER, NEVER, 1'b0);     // data ack at T+3
    run_seq(4'b0110, NEVER, 1, 3, 1'b0);         // IO ack T+2, inst 3 after rise
    run_seq(4'b1000, 1, 4, 2, 1'b0);             // full hold then all domains
    run_seq(4'b0011, 3, NEVER, NEVER, 1'b0);     // IO times out
    run_seq(4'b0000, NEVER, NEVER, NEVER, 1'b0); // flag cleared, immediate response
    run_seq(4'b0100, NEVER, NEVER, TMO-1, 1'b0); // ack on the timeout cycle wins
    run_seq(4'b0100, NEVER, NEVER, TMO, 1'b0);   // inst times out
    run_seq(4'b0000, NEVER, NEVER, NEVER, 1'b1);
    run_seq(4'b1111, 0, TMO-1, NEVER, 1'b1);

    // Abort during PHASE2.
    @(negedge clk);
    bus.SoftwareResetIn = 1'b1; bus.ResetVectorIn = 4'b0100;
    @(negedge clk);
    bus.SoftwareResetIn = 1'b0; bus.ResetVectorIn = '0;
    @(negedge clk);
    chk("abort_pre_InstReq", 0, {3'b0, bus.InstResetReq}, 4'h1);
    chk("abort_pre_Busy", 0, {3'b0, bus.Busy}, 4'h1);
    #2 async_rst = 1'b1;
    #1;
    chk("abort_Reqs", 0, {1'b0, bus.InstResetReq, bus.IOResetReq, bus.DataResetReq}, 4'h0);
    chk("abort_Busy", 0, {3'b0, bus.Busy}, 4'h0);
    chk("abort_Resp", 0, {3'b0, bus.ResetResponseOut}, 4'h0);
    chk("abort_Tmo", 0, {1'b0, bus.TimedOutDomains}, 4'h0);
    @(negedge clk);
    async_rst = 1'b0;
    bus.InstResetAck = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      bus.InstResetAck = 1'b0;
      chk("post_abort_Reqs", i, {1'b0, bus.InstResetReq, bus.IOResetReq, bus.DataResetReq}, 4'h0);
      chk("post_abort_Resp", i, {3'b0, bus.ResetResponseOut}, 4'h0);
      chk("post_abort_Busy", i, {3'b0, bus.Busy}, 4'h0);
    end
    tmo_prev = '0;
    run_seq(4'b0010, NEVER, 0, NEVER, 1'b0);

    for (int i = 0; i < 30; i++)
      run_seq(4'($urandom), $urandom_range(0, TMO+1), $urandom_range(0, TMO+1),
              $urandom_range(0, TMO+1), 1'($urandom_range(0, 1)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
